// File: rtl/rgb_pixel_writer_pkg.sv
// Shared types and constants for the RGB pixel writer: FSM states, clipped pixel type, frame geometry.
package rgb_pixel_writer_pkg;

  localparam logic [17:0] RGB_BASE_ADDR = 18'd146944;
  localparam int          IMG_W         = 320;
  localparam int          IMG_H         = 240;

  typedef enum logic [2:0] {
    IDLE,
    GET_E,
    GET_O,
    WR0,
    WR1,
    WR2,
    DONE
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

endpackage

// File: rtl/rgb_pixel_writer_if.sv
// Pixel stream (valid/ready) plus granted SRAM write bus; slave is the writer, master the surrounding system.
interface rgb_pixel_writer_if;
  logic               pix_valid;
  logic               pix_ready;
  logic signed [31:0] pix_r;
  logic signed [31:0] pix_g;
  logic signed [31:0] pix_b;
  logic               sram_grant;
  logic [17:0]        SRAM_address;
  logic [15:0]        SRAM_write_data;
  logic               SRAM_we_n;

  modport slave (
    input  pix_valid, pix_r, pix_g, pix_b, sram_grant,
    output pix_ready, SRAM_address, SRAM_write_data, SRAM_we_n
  );

  modport master (
    output pix_valid, pix_r, pix_g, pix_b, sram_grant,
    input  pix_ready, SRAM_address, SRAM_write_data, SRAM_we_n
  );
endinterface

// File: rtl/rgb_pixel_writer_clip.sv
// Combinational saturator: signed 32-bit channel to unsigned 8-bit, zero latency, no flow control.
module rgb_clip (
  input  logic signed [31:0] v,
  output logic [7:0]         c
);

  always_comb begin
    if (v < 32'sd0)        c = 8'd0;
    else if (v > 32'sd255) c = 8'd255;
    else                   c = v[7:0];
  end

endmodule

// File: rtl/rgb_pixel_writer.sv
// Clips a pixel pair, packs it into three 16-bit words and writes them to SRAM when granted.
// Best case 5 cycles per pair; pix_ready only in GET_E/GET_O, a missing grant stalls the write state.
module rgb_pixel_writer
  import rgb_pixel_writer_pkg::*;
#(
  parameter logic [17:0] RGB_BASE = RGB_BASE_ADDR,
  parameter int          PIXELS   = IMG_W * IMG_H
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                done,
  rgb_pixel_writer_if.slave   bus
);

  localparam int CW = $clog2(PIXELS + 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   pix_cnt;
  logic [17:0]     wr_ptr;
  rgb8_t           pix_e, pix_o, clip_now;
  logic            issue;
  logic            start_ok;
  logic            last_pair;
  logic [15:0]     word;

  rgb_clip u_clip_r (.v(bus.pix_r), .c(clip_now.r));
  rgb_clip u_clip_g (.v(bus.pix_g), .c(clip_now.g));
  rgb_clip u_clip_b (.v(bus.pix_b), .c(clip_now.b));

  assign start_ok  = start && (state == IDLE || state == DONE);
  assign last_pair = (pix_cnt == CW'(PIXELS - 2));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)          state_nxt = GET_E;
      GET_E:      if (bus.pix_valid)  state_nxt = GET_O;
      GET_O:      if (bus.pix_valid)  state_nxt = WR0;
      WR0:        if (bus.sram_grant) state_nxt = WR1;
      WR1:        if (bus.sram_grant) state_nxt = WR2;
      WR2:        if (bus.sram_grant) state_nxt = last_pair ? DONE : GET_E;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.pix_ready = (state == GET_E) || (state == GET_O);
    done          = (state == DONE);
    issue         = bus.sram_grant && (state == WR0 || state == WR1 || state == WR2);
    case (state)
      WR0:     word = {pix_e.r, pix_e.g};
      WR1:     word = {pix_e.b, pix_o.r};
      WR2:     word = {pix_o.g, pix_o.b};
      default: word = 16'd0;
    endcase
  end

  // Pointer only rewinds on start, so a frame always lands in one contiguous block.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt             <= '0;
      wr_ptr              <= RGB_BASE;
      pix_e               <= '0;
      pix_o               <= '0;
      bus.SRAM_address    <= '0;
      bus.SRAM_write_data <= '0;
      bus.SRAM_we_n       <= 1'b1;
    end else begin
      if (start_ok) begin
        pix_cnt <= '0;
        wr_ptr  <= RGB_BASE;
      end
      if (bus.pix_valid && state == GET_E) pix_e <= clip_now;
      if (bus.pix_valid && state == GET_O) pix_o <= clip_now;
      bus.SRAM_we_n <= !issue;
      if (issue) begin
        bus.SRAM_address    <= wr_ptr;
        bus.SRAM_write_data <= word;
        wr_ptr              <= wr_ptr + 18'd1;
        if (state == WR2) pix_cnt <= pix_cnt + CW'(2);
      end
    end
  end

endmodule
